// File: rtl/fx_pkg.sv
// Shared definitions for the square-wave channel effect units
// (vibrato and portamento): field widths, default LFO prescale and
// the vibrato peak helper.
package fx_pkg;

    localparam int NOTE_W   = 6;
    localparam int OFFSET_W = 3;
    localparam int SPEED_W  = 2;
    localparam int DEPTH_W  = 2;

    // log2 of clk50mhz cycles per LFO step at speed 0
    localparam int VIB_PRESCALE_BASE_DEFAULT = 17;

    // Direction of the LFO magnitude sweep
    typedef enum logic {
        PH_FALL = 1'b0,
        PH_RISE = 1'b1
    } lfo_phase_e;

    // Peak magnitude of the vibrato triangle: 2*depth+1 -> {1,3,5,7}
    function automatic logic [OFFSET_W-1:0] vib_peak(input logic [DEPTH_W-1:0] depth);
        return {depth, 1'b1};
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The output pulse is one cycle wide and appears three clock edges
// after the asynchronous input rises.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    // Bring the async level into the clock domain and flag its rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/fx_vibrato.sv
// Pitch-vibrato effect for a square-wave channel. Passes the note index
// through and produces a triangle-LFO fine-detune offset (magnitude plus
// direction). Optional macro FX_VIB_RETRIG_EN restarts the LFO on each
// rising edge of note_clk; without it note_clk is ignored.
module fx_vibrato
    import fx_pkg::*;
#(
    parameter int PRESCALE_BASE = VIB_PRESCALE_BASE_DEFAULT
) (
    input  logic                clk50mhz,
    input  logic                rst,
    input  logic [NOTE_W-1:0]   note_in,
    input  logic                note_clk,
    input  logic                en,
    input  logic [SPEED_W-1:0]  speed,
    input  logic [DEPTH_W-1:0]  depth,
    output logic [NOTE_W-1:0]   note_out,
    output logic [OFFSET_W-1:0] offset_mul,
    output logic                offset_dir
);

    // Prescaler must reach 2^(PRESCALE_BASE+3)-1 at the slowest speed
    localparam int CNT_W = PRESCALE_BASE + 3;
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    logic [CNT_W-1:0]    r_presc;
    logic [OFFSET_W-1:0] r_mag;
    lfo_phase_e          r_phase;
    logic                r_dir;

    logic [CNT_W-1:0]    w_terminal;
    logic                w_step;
    logic                w_retrig;
    logic [OFFSET_W-1:0] w_peak;
    logic [CNT_W-1:0]    w_presc_nxt;
    logic [OFFSET_W-1:0] w_mag_nxt;
    lfo_phase_e          w_phase_nxt;
    logic                w_dir_nxt;

    // Terminal count 2^(PRESCALE_BASE+speed)-1 as a mask of low ones
    assign w_terminal = ~(CNT_ONES << (PRESCALE_BASE + 32'(speed)));
    assign w_step     = (r_presc == w_terminal);
    assign w_peak     = vib_peak(depth);

`ifdef FX_VIB_RETRIG_EN
    sync_edge_det u_note_sync (
        .clk     (clk50mhz),
        .rst     (rst),
        .i_async (note_clk),
        .o_pulse (w_retrig)
    );
`else
    logic w_unused_note_clk;
    assign w_unused_note_clk = note_clk;
    assign w_retrig          = 1'b0;
`endif

    // Next LFO and prescaler state: disable or retrigger force the start
    // state; otherwise the triangle advances by one on each step strobe
    always_comb begin
        w_presc_nxt = r_presc + 1'b1;
        w_mag_nxt   = r_mag;
        w_phase_nxt = r_phase;
        w_dir_nxt   = r_dir;
        if (!en || w_retrig) begin
            w_presc_nxt = '0;
            w_mag_nxt   = '0;
            w_phase_nxt = PH_RISE;
            w_dir_nxt   = 1'b1;
        end else if (w_step) begin
            w_presc_nxt = '0;
            case (r_phase)
                PH_RISE: begin
                    if (r_mag < w_peak) begin
                        w_mag_nxt = r_mag + 1'b1;
                    end else if (r_mag == 3'd1) begin
                        w_mag_nxt   = '0;
                        w_dir_nxt   = ~r_dir;
                    end else begin
                        w_mag_nxt   = r_mag - 1'b1;
                        w_phase_nxt = PH_FALL;
                    end
                end
                default: begin
                    if (r_mag > 3'd1) begin
                        w_mag_nxt = r_mag - 1'b1;
                    end else begin
                        w_mag_nxt   = '0;
                        w_phase_nxt = PH_RISE;
                        w_dir_nxt   = ~r_dir;
                    end
                end
            endcase
        end
    end

    // Register LFO state, note pass-through and the gated offset outputs
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            r_presc    <= '0;
            r_mag      <= '0;
            r_phase    <= PH_RISE;
            r_dir      <= 1'b1;
            note_out   <= '0;
            offset_mul <= '0;
            offset_dir <= 1'b0;
        end else begin
            r_presc    <= w_presc_nxt;
            r_mag      <= w_mag_nxt;
            r_phase    <= w_phase_nxt;
            r_dir      <= w_dir_nxt;
            note_out   <= note_in;
            offset_mul <= en ? w_mag_nxt : '0;
            offset_dir <= en ? w_dir_nxt : 1'b0;
        end
    end

endmodule

// File: tb/tb_fx_vibrato.sv
// Bench for fx_vibrato with PRESCALE_BASE=2. A reference model describes
// the vibrato as a queue of upcoming triangle values released every
// 2^(2+speed) enabled cycles; a monitor compares every cycle's outputs.
// Honours FX_VIB_RETRIG_EN in the same way as the design.
module tb_fx_vibrato;

    localparam int PB = 2;

    logic       clk50mhz = 1'b0;
    logic       rst      = 1'b1;
    logic [5:0] note_in  = 6'd0;
    logic       note_clk = 1'b0;
    logic       en       = 1'b0;
    logic [1:0] speed    = 2'd0;
    logic [1:0] depth    = 2'd0;
    logic [5:0] note_out;
    logic [2:0] offset_mul;
    logic       offset_dir;

    typedef struct {
        logic [5:0] note;
        logic [2:0] mul;
        logic       dir;
    } exp_t;

    typedef struct {
        int mag;
        bit dir;
    } step_t;

    exp_t  expQ[$];
    step_t stepQ[$];

    int checks = 0;
    int errors = 0;

    int       curMag   = 0;
    bit       curDir   = 1'b1;
    int       cyc      = 0;
    bit       fresh    = 1'b1;
    int       runDepth = 0;
    bit [4:0] clkHist  = '0;
    bit       randNote = 1'b0;

    fx_vibrato #(.PRESCALE_BASE(PB)) dut (
        .clk50mhz   (clk50mhz),
        .rst        (rst),
        .note_in    (note_in),
        .note_clk   (note_clk),
        .en         (en),
        .speed      (speed),
        .depth      (depth),
        .note_out   (note_out),
        .offset_mul (offset_mul),
        .offset_dir (offset_dir)
    );

    // 50 MHz clock
    always #10 clk50mhz = ~clk50mhz;

    // One half-period of the triangle: 1..p..1 in direction d, then 0 with d flipped
    function automatic void pushHalf(int p, bit d);
        for (int j = 1; j <= 2 * p; j++) begin
            step_t s;
            s.mag = (j <= p) ? j : 2 * p - j;
            s.dir = (j == 2 * p) ? ~d : d;
            stepQ.push_back(s);
        end
    endfunction

    function automatic bit modelRising();
        return (curMag == 0) || (curMag == 2 * runDepth + 1) ||
               (stepQ.size() > 0 && stepQ[0].mag > curMag);
    endfunction

    // Depth changed mid-run: while rising, climb to the new peak (if still
    // below it), then descend to 0 with the direction flipping at 0
    function automatic void reshape(int p);
        int top;
        if (modelRising()) begin
            stepQ.delete();
            top = (curMag >= p) ? curMag : p;
            for (int m = curMag + 1; m <= p; m++) begin
                step_t s;
                s.mag = m;
                s.dir = curDir;
                stepQ.push_back(s);
            end
            for (int m = top - 1; m >= 1; m--) begin
                step_t s;
                s.mag = m;
                s.dir = curDir;
                stepQ.push_back(s);
            end
            begin
                step_t s;
                s.mag = 0;
                s.dir = ~curDir;
                stepQ.push_back(s);
            end
        end
    endfunction

    // Reference model: computes each cycle's expected outputs and queues them
    always @(posedge clk50mhz) begin : model
        exp_t  e;
        step_t s;
        int    t;
        int    p;
        bit    retrig;
        if (rst) begin
            e.note  = 6'd0;
            e.mul   = 3'd0;
            e.dir   = 1'b0;
            fresh   = 1'b1;
            clkHist = '0;
            stepQ.delete();
        end else begin
            clkHist = {clkHist[3:0], note_clk};
`ifdef FX_VIB_RETRIG_EN
            retrig = clkHist[3] & ~clkHist[4];
`else
            retrig = 1'b0;
`endif
            e.note = note_in;
            if (!en) begin
                fresh = 1'b1;
                e.mul = 3'd0;
                e.dir = 1'b0;
            end else if (fresh || retrig) begin
                curMag   = 0;
                curDir   = 1'b1;
                stepQ.delete();
                runDepth = int'(depth);
                cyc      = retrig ? 0 : 1;
                fresh    = 1'b0;
                e.mul    = 3'd0;
                e.dir    = 1'b1;
            end else begin
                cyc++;
                t = 1 << (PB + int'(speed));
                if (cyc % t == 0) begin
                    p = 2 * int'(depth) + 1;
                    if (int'(depth) != runDepth) begin
                        reshape(p);
                        runDepth = int'(depth);
                    end
                    if (stepQ.size() == 0) pushHalf(p, curDir);
                    s      = stepQ.pop_front();
                    curMag = s.mag;
                    curDir = s.dir;
                end
                e.mul = 3'(curMag);
                e.dir = curDir;
            end
        end
        expQ.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the expected outputs for the cycle and compares them
    always @(negedge clk50mhz) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("note_out",   8'(note_out),   8'(e.note));
            checkOutput("offset_mul", 8'(offset_mul), 8'(e.mul));
            checkOutput("offset_dir", 8'(offset_dir), 8'(e.dir));
        end
    end

    // Random note index every cycle while enabled
    always @(negedge clk50mhz) begin
        if (randNote) note_in = 6'($urandom);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk50mhz);
    endtask

    // Wait until the model reaches a magnitude and sweep direction (mode 0
    // falling, 1 rising, 2 either), bounded by a cycle budget
    task automatic waitModel(input int mag, input int mode, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk50mhz);
            if (curMag == mag && !fresh &&
                (mode == 2 || int'(modelRising()) == mode)) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timeout, got no mag %0d, expected it within %0d cycles", name, mag, budget);
        end
    endtask

    task automatic applyStimulus();
        // Reset with enable high and a fixed note
        rst = 1'b1; en = 1'b1; note_in = 6'd33; depth = 2'd0; speed = 2'd0;
        idle(3);
        rst = 1'b0;
        idle(40);

        // Slowest, deepest sweep over a full period
        en = 1'b0; idle(2);
        depth = 2'd3; speed = 2'd3; en = 1'b1;
        idle(1000);

        // Enable gating mid-sweep at magnitude 5
        en = 1'b0; idle(2);
        speed = 2'd0; en = 1'b1;
        waitModel(5, 2, 200, "gate_wait");
        en = 1'b0; idle(3);
        en = 1'b1; idle(40);

        // note_clk pulse while falling through magnitude 4
        waitModel(4, 0, 200, "retrig_wait");
        note_clk = 1'b1; idle(3);
        note_clk = 1'b0; idle(40);

        // Depth reduction while rising at magnitude 5
        en = 1'b0; idle(2);
        depth = 2'd3; speed = 2'd0; en = 1'b1;
        waitModel(5, 1, 200, "depth_wait");
        depth = 2'd0;
        idle(60);

        // Randomized segments
        randNote = 1'b1;
        for (int seg = 0; seg < 12; seg++) begin
            int len;
            en = 1'b0;
            depth = 2'($urandom);
            speed = 2'($urandom_range(0, 2));
            idle($urandom_range(1, 3));
            en = 1'b1;
            len = $urandom_range(100, 300);
            for (int c = 0; c < len; c++) begin
                @(negedge clk50mhz);
                en = ($urandom_range(0, 99) != 0);
                if ($urandom_range(0, 19) == 0) note_clk = ~note_clk;
                if (seg == 6 && c == 50) rst = 1'b1;
                else rst = 1'b0;
            end
        end
        randNote = 1'b0;
        rst = 1'b0; en = 1'b0; note_clk = 1'b0;
        idle(4);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
